// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code checker: FSM encodings, default code
// width and the Gray-to-binary conversion helper.
package gray_pkg;

  localparam int GRAY_W = 3;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    S_INIT  = ST_INIT,
    S_TRACK = ST_TRACK,
    S_FAULT = ST_FAULT
  } state_e;

  // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_checker_conv.sv
// Combinational Gray-to-binary converter (module gray2bin_conv). Uses the
// package helper at the default width and a per-bit XOR reduction otherwise.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  generate
    if (WIDTH == GRAY_W) begin : g_pkg
      assign bin = gray2bin(gray);
    end else begin : g_generic
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
      end
    end
  endgenerate

endmodule

// File: rtl/gray_checker.sv
// Gray counter observer: converts sampled Gray codes, checks each step is a hold
// or +1 (mod 2^WIDTH), counts wraps and flags faults. Macro GRAY_CHK_OVF_EN adds
// an Overflow_in consistency check in TRACK.
module gray_checker
  import gray_pkg::*;
#(
  parameter int WIDTH      = GRAY_W,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  En,
  input  logic                  Clr,
  input  logic [WIDTH-1:0]      Gray_in,
  input  logic                  Overflow_in,
  output logic [WIDTH-1:0]      Bin_out,
  output logic                  Bin_valid,
  output logic                  Step_err,
  output logic                  Err_sticky,
  output logic [WRAP_CNT_W-1:0] Wrap_cnt,
  output logic [1:0]            State
);

  // Handshake: En qualifies Gray_in/Overflow_in and there is no backpressure,
  // so every En cycle is consumed; Bin_valid pulses one cycle later to mark a
  // freshly written Bin_out.

  localparam logic [WIDTH-1:0]      BIN_MAX  = '1;
  localparam logic [WRAP_CNT_W-1:0] WRAP_MAX = '1;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic                    valid_q, valid_d;
  logic                    serr_q, serr_d;
  logic                    sticky_q, sticky_d;
  logic [WRAP_CNT_W-1:0]   wrap_q, wrap_d;

  logic [WIDTH-1:0]        n_bin;
  logic [WIDTH-1:0]        bin_inc;
  logic                    step_ok;
  logic                    is_wrap;
  logic                    ovf_bad;

  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .gray (Gray_in),
    .bin  (n_bin)
  );

  assign bin_inc = bin_q + WIDTH'(1);
  assign step_ok = (n_bin == bin_q) || (n_bin == bin_inc);
  assign is_wrap = (bin_q == BIN_MAX) && (n_bin == '0);

`ifdef GRAY_CHK_OVF_EN
  assign ovf_bad = Overflow_in != (n_bin == BIN_MAX);
`else
  logic unused_ovf;
  assign unused_ovf = Overflow_in;
  assign ovf_bad    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    valid_d  = 1'b0;
    serr_d   = 1'b0;
    sticky_d = sticky_q;
    wrap_d   = wrap_q;
    if (Clr) begin
      // A sample arriving with Clr is dropped; Bin_out keeps its last value.
      state_d  = S_INIT;
      sticky_d = 1'b0;
      wrap_d   = '0;
    end else if (En) begin
      bin_d   = n_bin;
      valid_d = 1'b1;
      case (state_q)
        S_INIT: begin
          state_d = S_TRACK;
        end
        S_TRACK: begin
          if (!step_ok || ovf_bad) begin
            serr_d   = 1'b1;
            sticky_d = 1'b1;
            state_d  = S_FAULT;
          end else if (is_wrap && (wrap_q != WRAP_MAX)) begin
            wrap_d = wrap_q + WRAP_CNT_W'(1);
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= S_INIT;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      serr_q   <= 1'b0;
      sticky_q <= 1'b0;
      wrap_q   <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      valid_q  <= valid_d;
      serr_q   <= serr_d;
      sticky_q <= sticky_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Bin_out    = bin_q;
  assign Bin_valid  = valid_q;
  assign Step_err   = serr_q;
  assign Err_sticky = sticky_q;
  assign Wrap_cnt   = wrap_q;
  assign State      = state_q;

endmodule

// File: tb/tb_gray_checker.sv
// Bench for gray_checker: a default instance plus a WRAP_CNT_W=2 instance share
// one stimulus stream; expectations come from a vector table and hand sequences.
module tb_gray_checker;
  import gray_pkg::*;

  localparam int   EXP_W = 18;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct packed {
    logic       rst_n;
    logic       clr;
    logic       en;
    logic [2:0] gray;
    logic       ovf;
    logic [2:0] bin;
    logic       valid;
    logic       serr;
    logic       sticky;
    logic [1:0] state;
    logic [7:0] wrap8;
    logic [1:0] wrap2;
  } vec_t;

  logic       Clk, Reset, En, Clr, Overflow_in;
  logic [2:0] Gray_in;
  logic [2:0] Bin_out, bin_b;
  logic       Bin_valid, Step_err, Err_sticky;
  logic       valid_b, serr_b, sticky_b;
  logic [7:0] Wrap_cnt;
  logic [1:0] wrap_b;
  logic [1:0] State, state_b;

  logic [EXP_W-1:0] exp_q[$];
  vec_t             vecs[$];
  int               n_cmp = 0;
  int               n_err = 0;

  gray_checker u_dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Clr(Clr),
    .Gray_in(Gray_in), .Overflow_in(Overflow_in),
    .Bin_out(Bin_out), .Bin_valid(Bin_valid), .Step_err(Step_err),
    .Err_sticky(Err_sticky), .Wrap_cnt(Wrap_cnt), .State(State)
  );

  gray_checker #(.WIDTH(3), .WRAP_CNT_W(2)) u_dut_w2 (
    .Clk(Clk), .Reset(Reset), .En(En), .Clr(Clr),
    .Gray_in(Gray_in), .Overflow_in(Overflow_in),
    .Bin_out(bin_b), .Bin_valid(valid_b), .Step_err(serr_b),
    .Err_sticky(sticky_b), .Wrap_cnt(wrap_b), .State(state_b)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] to_gray(input int b);
    logic [2:0] x;
    x = 3'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic clr, input logic en,
                              input logic [2:0] gray, input logic ovf,
                              input logic [2:0] bin, input logic valid,
                              input logic serr, input logic sticky,
                              input logic [1:0] st, input logic [7:0] w8,
                              input logic [1:0] w2);
    vec_t v;
    v.rst_n = rst_n; v.clr = clr; v.en = en; v.gray = gray; v.ovf = ovf;
    v.bin = bin; v.valid = valid; v.serr = serr; v.sticky = sticky;
    v.state = st; v.wrap8 = w8; v.wrap2 = w2;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + scoreboard: push expectation on drive, pop after the edge
  task automatic apply(input vec_t v);
    logic [EXP_W-1:0] e;
    Reset = v.rst_n; Clr = v.clr; En = v.en;
    Gray_in = v.gray; Overflow_in = v.ovf;
    exp_q.push_back({v.wrap2, v.wrap8, v.state, v.sticky, v.serr, v.valid, v.bin});
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("bin_out",    8'(Bin_out),    8'(e[2:0]));
    check("bin_valid",  8'(Bin_valid),  8'(e[3]));
    check("step_err",   8'(Step_err),   8'(e[4]));
    check("err_sticky", 8'(Err_sticky), 8'(e[5]));
    check("state",      8'(State),      8'(e[7:6]));
    check("wrap_cnt",   Wrap_cnt,       e[15:8]);
    check("w2_bin_out", 8'(bin_b),      8'(e[2:0]));
    check("w2_valid",   8'(valid_b),    8'(e[3]));
    check("w2_step_err",8'(serr_b),     8'(e[4]));
    check("w2_sticky",  8'(sticky_b),   8'(e[5]));
    check("w2_state",   8'(state_b),    8'(e[7:6]));
    check("w2_wrap_cnt",8'(wrap_b),     8'(e[17:16]));
  endtask

  initial begin
    int e_bin, e_w, w, w2, nb;
    logic en_r, st_r;

    Reset = 1'b0; Clr = 1'b0; En = 1'b0; Gray_in = 3'b000; Overflow_in = 1'b0;

    // reset (En ignored), then full legal cycle with one wrap
    vecs.push_back(mk(L,L,L,3'b000,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    vecs.push_back(mk(L,H,H,3'b101,H, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    for (int b = 0; b < 8; b++)
      vecs.push_back(mk(H,L,H,to_gray(b),(b == 7), 3'(b),H,L,L,ST_TRACK,8'd0,2'd0));
    vecs.push_back(mk(H,L,H,3'b000,L, 3'd0,H,L,L,ST_TRACK,8'd1,2'd1));
    // holds then idle cycles at Gray 011
    vecs.push_back(mk(H,L,H,3'b001,L, 3'd1,H,L,L,ST_TRACK,8'd1,2'd1));
    vecs.push_back(mk(H,L,H,3'b011,L, 3'd2,H,L,L,ST_TRACK,8'd1,2'd1));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(H,L,H,3'b011,L, 3'd2,H,L,L,ST_TRACK,8'd1,2'd1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(H,L,L,3'b011,L, 3'd2,L,L,L,ST_TRACK,8'd1,2'd1));
    // walk to bin 1, then illegal jump to bin 3, then FAULT behaviour
    for (int b = 3; b < 8; b++)
      vecs.push_back(mk(H,L,H,to_gray(b),(b == 7), 3'(b),H,L,L,ST_TRACK,8'd1,2'd1));
    vecs.push_back(mk(H,L,H,3'b000,L, 3'd0,H,L,L,ST_TRACK,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b001,L, 3'd1,H,L,L,ST_TRACK,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b010,L, 3'd3,H,H,H,ST_FAULT,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b000,L, 3'd0,H,L,H,ST_FAULT,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b101,L, 3'd6,H,L,H,ST_FAULT,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b100,H, 3'd7,H,L,H,ST_FAULT,8'd2,2'd2));
    vecs.push_back(mk(H,L,H,3'b000,L, 3'd0,H,L,H,ST_FAULT,8'd2,2'd2));
    vecs.push_back(mk(H,L,L,3'b000,L, 3'd0,L,L,H,ST_FAULT,8'd2,2'd2));
    // Clr with a concurrent sample, then a fresh reference
    vecs.push_back(mk(H,H,H,3'b110,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    vecs.push_back(mk(H,L,L,3'b110,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    vecs.push_back(mk(H,L,H,3'b110,L, 3'd4,H,L,L,ST_TRACK,8'd0,2'd0));
    for (int b = 5; b < 8; b++)
      vecs.push_back(mk(H,L,H,to_gray(b),(b == 7), 3'(b),H,L,L,ST_TRACK,8'd0,2'd0));
    vecs.push_back(mk(H,L,H,3'b000,L, 3'd0,H,L,L,ST_TRACK,8'd1,2'd1));

    #2;
    foreach (vecs[i]) apply(vecs[i]);

    // five full cycles: 8-bit counter keeps counting, 2-bit one saturates
    apply(mk(L,L,L,3'b000,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    apply(mk(H,L,H,3'b000,L, 3'd0,H,L,L,ST_TRACK,8'd0,2'd0));
    for (int c = 1; c <= 5; c++) begin
      for (int s = 1; s <= 8; s++) begin
        nb = s % 8;
        w  = (nb == 0) ? c : c - 1;
        w2 = (w > 3) ? 3 : w;
        apply(mk(H,L,H,to_gray(nb),(nb == 7), 3'(nb),H,L,L,ST_TRACK,8'(w),2'(w2)));
      end
    end
    apply(mk(H,L,H,3'b001,L, 3'd1,H,L,L,ST_TRACK,8'd5,2'd3));
    apply(mk(H,L,H,3'b011,L, 3'd2,H,L,L,ST_TRACK,8'd5,2'd3));
    // reset mid-sequence beats Clr and En
    apply(mk(L,H,H,3'b110,H, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    apply(mk(H,L,H,3'b101,L, 3'd6,H,L,L,ST_TRACK,8'd0,2'd0));

    // random legal walk with random enables
    e_bin = 6; e_w = 0;
    for (int k = 0; k < 64; k++) begin
      en_r = 1'($urandom_range(0, 1));
      st_r = 1'($urandom_range(0, 1));
      nb = st_r ? (e_bin + 1) % 8 : e_bin;
      if (en_r && st_r && e_bin == 7) e_w++;
      if (en_r) e_bin = nb;
      w2 = (e_w > 3) ? 3 : e_w;
      apply(mk(H,L,en_r,to_gray(nb),(nb == 7), 3'(e_bin),en_r,L,L,ST_TRACK,8'(e_w),2'(w2)));
    end

    // overflow consistency
    apply(mk(L,L,L,3'b000,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    apply(mk(H,L,H,3'b101,L, 3'd6,H,L,L,ST_TRACK,8'd0,2'd0));
`ifdef GRAY_CHK_OVF_EN
    apply(mk(H,L,H,3'b100,L, 3'd7,H,H,H,ST_FAULT,8'd0,2'd0));
`else
    apply(mk(H,L,H,3'b100,L, 3'd7,H,L,L,ST_TRACK,8'd0,2'd0));
`endif
    apply(mk(L,L,L,3'b000,L, 3'd0,L,L,L,ST_INIT,8'd0,2'd0));
    apply(mk(H,L,H,3'b101,L, 3'd6,H,L,L,ST_TRACK,8'd0,2'd0));
    apply(mk(H,L,H,3'b100,H, 3'd7,H,L,L,ST_TRACK,8'd0,2'd0));
    apply(mk(H,L,H,3'b000,L, 3'd0,H,L,L,ST_TRACK,8'd1,2'd1));
    // illegal step and overflow mismatch together: a single pulse
    apply(mk(H,L,H,3'b100,L, 3'd7,H,H,H,ST_FAULT,8'd1,2'd1));
    apply(mk(H,L,L,3'b100,L, 3'd7,L,L,H,ST_FAULT,8'd1,2'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
